// File: rtl/dsp_wresp_pkg.sv
// Shared constants and order-entry packing helpers for the write-response dispatcher.
package dsp_wresp_pkg;

  localparam int unsigned ORDER_STRICT = 0;
  localparam int unsigned ORDER_PER_ID = 1;

  // An order entry is packed as {slv, id}.
  function automatic int unsigned order_entry_w(input int unsigned slv_id_w,
                                                input int unsigned id_w);
    return slv_id_w + id_w;
  endfunction

endpackage

// File: rtl/wresp_slv_fifo.sv
// Per-slave response FIFO: synchronous active-high reset, first-word-fall-through head.
module wresp_slv_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr, rd;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr       = wr_en_i & ~full_o;
    rd       = rd_en_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CNT_W'(wr) - CNT_W'(rd);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/dsp_wresp_id_order.sv
// Write-response dispatcher: per-slave B buffering, collapsing {slv, id} order queue,
// strict or per-ID ordered return to the master through a registered B port.
module dsp_wresp_id_order
  import dsp_wresp_pkg::*;
#(
  parameter int unsigned SLV_AMT         = 2,
  parameter int unsigned OUTSTANDING_AMT = 8,
  parameter int unsigned RESP_FIFO_DEPTH = 4,
  parameter int unsigned TRANS_MST_ID_W  = 5,
  parameter int unsigned TRANS_WR_RESP_W = 2,
  parameter int unsigned ORDER_MODE      = ORDER_PER_ID,
  parameter int unsigned SLV_ID_W        = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
  parameter int unsigned CNT_W           = $clog2(OUTSTANDING_AMT + 1)
) (
  input  logic                                 ACLK_i,
  input  logic                                 ARESET_i,
  input  logic [SLV_ID_W-1:0]                  dsp_AW_slv_id_i,
  input  logic [TRANS_MST_ID_W-1:0]            dsp_AW_mst_id_i,
  input  logic                                 dsp_AW_shift_en_i,
  output logic                                 dsp_AW_stall_o,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]    sa_BID_i,
  input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]   sa_BRESP_i,
  input  logic [SLV_AMT-1:0]                   sa_BVALID_i,
  output logic [SLV_AMT-1:0]                   sa_BREADY_o,
  output logic [TRANS_MST_ID_W-1:0]            m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]           m_BRESP_o,
  output logic                                 m_BVALID_o,
  input  logic                                 m_BREADY_i,
  output logic [CNT_W-1:0]                     outstanding_cnt_o,
  output logic                                 err_overflow_o
);

  localparam int unsigned ID_W    = TRANS_MST_ID_W;
  localparam int unsigned RW      = TRANS_WR_RESP_W;
  localparam int unsigned ENTRY_W = order_entry_w(SLV_ID_W, ID_W);
  localparam int unsigned FIFO_W  = ID_W + RW;
  localparam int unsigned IDX_W   = $clog2(OUTSTANDING_AMT);

  logic [ENTRY_W-1:0]  queue_q [OUTSTANDING_AMT];
  logic [ENTRY_W-1:0]  queue_d [OUTSTANDING_AMT];
  logic [CNT_W-1:0]    count_q, count_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic [RW-1:0]       bresp_q, bresp_d;
  logic                err_q, err_d;

  logic [SLV_AMT-1:0]  fifo_full, fifo_empty, fifo_rd;
  logic [FIFO_W-1:0]   fifo_head [SLV_AMT];

  logic                q_full, load_ok, push, pop;
  logic                sel_found, elig;
  logic [IDX_W-1:0]    sel_idx;
  logic [SLV_ID_W-1:0] sel_slv, ent_slv;
  logic [ID_W-1:0]     ent_id;
  logic [CNT_W-1:0]    wr_idx;

  for (genvar s = 0; s < SLV_AMT; s++) begin : g_slv
    wresp_slv_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (RESP_FIFO_DEPTH)
    ) u_fifo (
      .clk_i     (ACLK_i),
      .rst_i     (ARESET_i),
      .wr_en_i   (sa_BVALID_i[s]),
      .wr_data_i ({sa_BID_i[s*ID_W +: ID_W], sa_BRESP_i[s*RW +: RW]}),
      .rd_en_i   (fifo_rd[s]),
      .rd_data_o (fifo_head[s]),
      .full_o    (fifo_full[s]),
      .empty_o   (fifo_empty[s])
    );
  end

  assign sa_BREADY_o = ~fifo_full;

  // Oldest eligible entry wins; in per-ID mode an older entry with the same ID blocks.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_slv   = '0;
    elig      = 1'b0;
    ent_slv   = '0;
    ent_id    = '0;
    for (int i = 0; i < OUTSTANDING_AMT; i++) begin
      ent_slv = queue_q[i][ENTRY_W-1 -: SLV_ID_W];
      ent_id  = queue_q[i][ID_W-1:0];
      elig    = (CNT_W'(i) < count_q) && ((ORDER_MODE == ORDER_PER_ID) || (i == 0));
      if (elig) begin
        elig = ~fifo_empty[ent_slv] && (fifo_head[ent_slv][FIFO_W-1 -: ID_W] == ent_id);
      end
      if (ORDER_MODE == ORDER_PER_ID) begin
        for (int j = 0; j < i; j++) begin
          if (queue_q[j][ID_W-1:0] == ent_id) elig = 1'b0;
        end
      end
      if (elig && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_slv   = ent_slv;
      end
    end
  end

  always_comb begin
    q_full  = (count_q == CNT_W'(OUTSTANDING_AMT));
    load_ok = ~bvalid_q | m_BREADY_i;
    pop     = load_ok & sel_found;
    push    = dsp_AW_shift_en_i & ~q_full;
    wr_idx  = pop ? count_q - 1'b1 : count_q;
    err_d   = err_q | (dsp_AW_shift_en_i & q_full);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    for (int i = 0; i < OUTSTANDING_AMT; i++) queue_d[i] = queue_q[i];
    // Collapse entries above the popped slot, then place the new entry at the tail.
    for (int i = 0; i < OUTSTANDING_AMT - 1; i++) begin
      if (pop && (IDX_W'(i) >= sel_idx)) queue_d[i] = queue_q[i+1];
    end
    for (int i = 0; i < OUTSTANDING_AMT; i++) begin
      if (push && (CNT_W'(i) == wr_idx)) queue_d[i] = {dsp_AW_slv_id_i, dsp_AW_mst_id_i};
    end

    for (int s = 0; s < SLV_AMT; s++) fifo_rd[s] = pop && (sel_slv == SLV_ID_W'(s));

    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    if (load_ok) begin
      bvalid_d = sel_found;
      if (sel_found) begin
        bid_d   = fifo_head[sel_slv][FIFO_W-1 -: ID_W];
        bresp_d = fifo_head[sel_slv][RW-1:0];
      end
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      count_q  <= '0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      err_q    <= err_d;
    end
  end

  // Entry payload needs no reset; validity comes from count_q.
  always_ff @(posedge ACLK_i) begin
    for (int i = 0; i < OUTSTANDING_AMT; i++) queue_q[i] <= queue_d[i];
  end

  assign dsp_AW_stall_o    = q_full;
  assign m_BID_o           = bid_q;
  assign m_BRESP_o         = bresp_q;
  assign m_BVALID_o        = bvalid_q;
  assign outstanding_cnt_o = count_q;
  assign err_overflow_o    = err_q;

endmodule
